// File: rtl/psum_acc_ctrl.sv
// Sequences the per-tile cross-channel psum reduction: SRAM reads into the
// output accumulator, then reduced per-batch results out to the output buffer.
module psum_acc_ctrl #(
  parameter int unsigned BATCHES  = 4,
  parameter int unsigned CHANNELS = 3,
  parameter int unsigned ADDR_W   = 10,
  parameter int unsigned DATA_W   = 21,
  parameter int unsigned PIX_W    = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [PIX_W-1:0]  num_pixels,
  output logic              psum_rd_en,
  output logic [ADDR_W-1:0] psum_rd_addr,
  input  logic [DATA_W-1:0] psum_rd_data,
  output logic              acc_en,
  output logic [DATA_W-1:0] acc_data_in,
  output logic              acc_data_in_valid,
  input  logic [DATA_W-1:0] acc_data_out,
  input  logic              acc_data_out_valid,
  input  logic              out_ready,
  output logic              out_wr_en,
  output logic [ADDR_W-1:0] out_wr_addr,
  output logic [DATA_W-1:0] out_wr_data,
  output logic              busy,
  output logic              done
);

  localparam int unsigned B_W   = (BATCHES  > 1) ? $clog2(BATCHES)  : 1;
  localparam int unsigned C_W   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int unsigned CNT_W = PIX_W + B_W + 1;

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_OUT, DRAIN, DONE} state_t;

  state_t             state;
  logic [PIX_W-1:0]   np_q;
  logic [PIX_W-1:0]   pix_q;
  logic [C_W-1:0]     c_q;
  logic [B_W-1:0]     b_q;
  logic [CNT_W-1:0]   out_cnt;
  logic [CNT_W-1:0]   total_q;

  logic               last_b;
  logic               last_c;
  logic               last_pix;
  logic               out_take;
  logic [ADDR_W-1:0]  rd_addr_nxt;

  // Position of the next read; address arithmetic deliberately wraps at ADDR_W.
  always_comb begin
    last_b      = (b_q == B_W'(BATCHES - 1));
    last_c      = (c_q == C_W'(CHANNELS - 1));
    last_pix    = (pix_q == PIX_W'(np_q - PIX_W'(1)));
    out_take    = acc_data_out_valid && busy && (out_cnt < total_q);
    rd_addr_nxt = ADDR_W'((ADDR_W'(c_q) * ADDR_W'(np_q) + ADDR_W'(pix_q)) * ADDR_W'(BATCHES)
                          + ADDR_W'(b_q));
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state             <= IDLE;
      np_q              <= '0;
      pix_q             <= '0;
      c_q               <= '0;
      b_q               <= '0;
      out_cnt           <= '0;
      total_q           <= '0;
      psum_rd_en        <= 1'b0;
      psum_rd_addr      <= '0;
      acc_en            <= 1'b0;
      acc_data_in       <= '0;
      acc_data_in_valid <= 1'b0;
      out_wr_en         <= 1'b0;
      out_wr_addr       <= '0;
      out_wr_data       <= '0;
      busy              <= 1'b0;
      done              <= 1'b0;
    end else begin
      psum_rd_en        <= 1'b0;
      out_wr_en         <= 1'b0;
      done              <= 1'b0;
      acc_data_in_valid <= psum_rd_en;
      if (psum_rd_en) begin
        acc_data_in <= psum_rd_data;
      end

      // Result collection runs independently of the read sequencer.
      if (out_take) begin
        out_wr_en   <= 1'b1;
        out_wr_addr <= ADDR_W'(out_cnt);
        out_wr_data <= acc_data_out;
        out_cnt     <= out_cnt + CNT_W'(1);
      end

      case (state)
        IDLE: begin
          if (start) begin
            if (num_pixels != '0) begin
              np_q    <= num_pixels;
              pix_q   <= '0;
              c_q     <= '0;
              b_q     <= '0;
              out_cnt <= '0;
              total_q <= CNT_W'(num_pixels) * CNT_W'(BATCHES);
              busy    <= 1'b1;
              state   <= ISSUE;
            end else begin
              state <= DONE;
            end
          end
        end
        ISSUE, WAIT_OUT: begin
          // WAIT_OUT resumes by issuing directly, so reads follow out_ready by one cycle.
          if (state == ISSUE || out_ready) begin
            psum_rd_en   <= 1'b1;
            psum_rd_addr <= rd_addr_nxt;
            acc_en       <= 1'b1;
            state        <= ISSUE;
            if (!last_b) begin
              b_q <= b_q + B_W'(1);
            end else begin
              b_q <= '0;
              if (!last_c) begin
                c_q <= c_q + C_W'(1);
              end else begin
                c_q <= '0;
                if (last_pix) begin
                  state <= DRAIN;
                end else begin
                  pix_q <= pix_q + PIX_W'(1);
                  state <= out_ready ? ISSUE : WAIT_OUT;
                end
              end
            end
          end
        end
        DRAIN: begin
          if (out_cnt == total_q) begin
            acc_en <= 1'b0;
            state  <= DONE;
          end
        end
        DONE: begin
          done   <= 1'b1;
          busy   <= 1'b0;
          acc_en <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
